// File: rtl/fft_out_reorder.sv
// fft_out_reorder
// Turns the bit-reversed sample stream of a serial FFT back into natural order.
// Two ping-pong banks of FRAME_LEN entries are used. Each incoming sample k is
// written to address bitrev(k) of the write bank, and the read side drains a
// FULL bank in ascending address order. Samples pass through unchanged.
//
// Parameters
//   DATA_W    sample width, {real[DATA_W-1:DATA_W/2], imag[DATA_W/2-1:0]}
//   FRAME_LEN points per frame, power of two in 2..64
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   data_in    bit-reversed input sample, qualified by in_valid
//   in_valid   input sample valid
//   in_ready   registered: current write bank is EMPTY
//   data_out   natural-order sample, 0 when out_valid is low
//   out_valid  current read bank is FULL
//   out_ready  downstream accepts data_out
//   out_last   marks natural index FRAME_LEN-1
//   err_drop   sticky flag: sample offered while in_ready was low
// Configuration
//   FFT_REORDER_ERR_EN  when defined, err_drop detection is built; otherwise
//                       err_drop is tied low.
module fft_out_reorder #(
    parameter int DATA_W    = 34,
    parameter int FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              err_drop
);

    localparam int             AW       = $clog2(FRAME_LEN);
    localparam logic [AW-1:0]  LAST_IDX = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0]  ONE_IDX  = AW'(1);

    // Mirror the index bits: MSB becomes LSB.
    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] idx);
        logic [AW-1:0] rev;
        rev = {AW{1'b0}};
        for (int i = 0; i < AW; i++) begin
            rev[i] = idx[AW-1-i];
        end
        return rev;
    endfunction

    // Bank storage, addressed as {bank, entry}.
    logic [DATA_W-1:0] mem_r [0:2*FRAME_LEN-1];

    logic [1:0]        full_r;
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [AW-1:0]     wr_cnt_r;
    logic [AW-1:0]     rd_idx_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [DATA_W-1:0] data_out_r;

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              wr_done_s;
    logic              rd_done_s;
    logic [1:0]        wr_set_s;
    logic [1:0]        rd_clr_s;
    logic [1:0]        full_nxt_s;
    logic              wr_bank_nxt_s;
    logic              rd_bank_nxt_s;
    logic [AW-1:0]     wr_cnt_nxt_s;
    logic [AW-1:0]     rd_idx_nxt_s;
    logic [AW:0]       wr_addr_s;
    logic [AW:0]       rd_addr_s;
    logic              in_ready_nxt_s;
    logic              out_valid_nxt_s;
    logic              out_last_nxt_s;
    logic [DATA_W-1:0] data_out_nxt_s;

    // Next-state computation; every output is precomputed so it can be registered.
    always_comb begin
        in_xfer_s  = in_valid & in_ready_r;
        out_xfer_s = out_valid_r & out_ready;
        wr_done_s  = in_xfer_s & (wr_cnt_r == LAST_IDX);
        rd_done_s  = out_xfer_s & out_last_r;

        // Writes only target an EMPTY bank and reads only a FULL one, so the
        // set and clear masks never hit the same bank on one edge.
        wr_set_s   = {wr_done_s & wr_bank_r, wr_done_s & ~wr_bank_r};
        rd_clr_s   = {rd_done_s & rd_bank_r, rd_done_s & ~rd_bank_r};
        full_nxt_s = (full_r | wr_set_s) & ~rd_clr_s;

        wr_bank_nxt_s = wr_bank_r ^ wr_done_s;
        rd_bank_nxt_s = rd_bank_r ^ rd_done_s;

        if (wr_done_s) begin
            wr_cnt_nxt_s = {AW{1'b0}};
        end else if (in_xfer_s) begin
            wr_cnt_nxt_s = wr_cnt_r + ONE_IDX;
        end else begin
            wr_cnt_nxt_s = wr_cnt_r;
        end

        if (rd_done_s) begin
            rd_idx_nxt_s = {AW{1'b0}};
        end else if (out_xfer_s) begin
            rd_idx_nxt_s = rd_idx_r + ONE_IDX;
        end else begin
            rd_idx_nxt_s = rd_idx_r;
        end

        wr_addr_s       = {wr_bank_r, bit_rev(wr_cnt_r)};
        rd_addr_s       = {rd_bank_nxt_s, rd_idx_nxt_s};
        in_ready_nxt_s  = ~full_nxt_s[wr_bank_nxt_s];
        out_valid_nxt_s = full_nxt_s[rd_bank_nxt_s];
        out_last_nxt_s  = out_valid_nxt_s & (rd_idx_nxt_s == LAST_IDX);

        // Forward the incoming sample when it lands on the entry read next,
        // since the memory still holds the old value during this cycle.
        if (!out_valid_nxt_s) begin
            data_out_nxt_s = {DATA_W{1'b0}};
        end else if (in_xfer_s && (wr_addr_s == rd_addr_s)) begin
            data_out_nxt_s = data_in;
        end else begin
            data_out_nxt_s = mem_r[rd_addr_s];
        end
    end

    // Sample storage; contents are not reset, stale data is never presented.
    always_ff @(posedge clk) begin
        if (in_xfer_s) begin
            mem_r[wr_addr_s] <= data_in;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r      <= 2'b00;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            wr_cnt_r    <= {AW{1'b0}};
            rd_idx_r    <= {AW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            data_out_r  <= {DATA_W{1'b0}};
        end else begin
            full_r      <= full_nxt_s;
            wr_bank_r   <= wr_bank_nxt_s;
            rd_bank_r   <= rd_bank_nxt_s;
            wr_cnt_r    <= wr_cnt_nxt_s;
            rd_idx_r    <= rd_idx_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_last_r  <= out_last_nxt_s;
            data_out_r  <= data_out_nxt_s;
        end
    end

`ifdef FFT_REORDER_ERR_EN
    logic err_drop_r;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop_r <= 1'b0;
        end else if (in_valid && !in_ready_r) begin
            err_drop_r <= 1'b1;
        end else begin
            err_drop_r <= err_drop_r;
        end
    end

    assign err_drop = err_drop_r;
`else
    assign err_drop = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign data_out  = data_out_r;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder (default parameters).
// Reference model: a queue of natural-order samples. A completed input frame
// is unscrambled with plain arithmetic and appended; each output transfer pops
// the front. Bank occupancy is derived from the queue length.
module tb_fft_out_reorder;

    localparam int DW = 34;
    localparam int FL = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          err_drop;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] fbuf [FL];
    int            wcnt = 0;
    bit            rdy_ok = 1'b0;
    bit            err_exp = 1'b0;

    always #5 clk = ~clk;

    fft_out_reorder #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .err_drop(err_drop)
    );

    function automatic int brev(input int k);
        int r = 0;
        int x = k;
        for (int j = 0; j < AW; j++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic int nfull();
        return (exp_q.size() + FL - 1) / FL;
    endfunction
    function automatic bit m_ready();
        return rdy_ok && (nfull() < 2);
    endfunction
    function automatic bit m_valid();
        return exp_q.size() > 0;
    endfunction
    function automatic bit m_last();
        return m_valid() && ((exp_q.size() % FL) == 1);
    endfunction
    function automatic logic [DW-1:0] m_data();
        return m_valid() ? exp_q[0] : '0;
    endfunction
    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    // One clock cycle of stimulus plus the matching model update.
    task automatic tick(input bit iv, input logic [DW-1:0] d, input bit ordy);
        bit            rdy_now;
        bit            in_x;
        bit            out_x;
        logic [DW-1:0] nat [FL];
        rdy_now   = m_ready();
        in_x      = iv && rdy_now;
        out_x     = m_valid() && ordy;
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
        if (out_x) void'(exp_q.pop_front());
        if (in_x) begin
            fbuf[wcnt] = d;
            wcnt++;
            if (wcnt == FL) begin
                for (int k = 0; k < FL; k++) nat[brev(k)] = fbuf[k];
                for (int i = 0; i < FL; i++) exp_q.push_back(nat[i]);
                wcnt = 0;
            end
        end
`ifdef FFT_REORDER_ERR_EN
        if (iv && !rdy_now) err_exp = 1'b1;
`endif
        rdy_ok   = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, err_drop} !== 4'b0000 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b last=%b err=%b dout=%h exp all 0",
                     in_ready, out_valid, out_last, err_drop, data_out);
        end
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rdy got %b exp 0", in_ready);
        end
        tick(1'b0, '0, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_rdy got %b exp 1", in_ready);
        end
    endtask

    task automatic test_bitrev_frame();
        int vals [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int k = 0; k < FL; k++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bitrev_fill k=%0d got vld=%b rdy=%b exp vld=0 rdy=1", k, out_valid, in_ready);
            end
            tick(1'b1, DW'(vals[k]), 1'b1);
        end
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== DW'(i) || out_last !== (i == FL - 1)) begin
                errors++;
                $display("FAIL bitrev_out i=%0d got vld=%b dout=%0d last=%b exp vld=1 dout=%0d last=%b",
                         i, out_valid, data_out, out_last, i, (i == FL - 1));
            end
            tick(1'b0, '0, 1'b1);
        end
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL bitrev_idle got vld=%b dout=%h exp vld=0 dout=0", out_valid, data_out);
        end
    endtask

    task automatic test_back_to_back();
        int  outs = 0;
        bit  seen = 1'b0;
        for (int c = 0; c < 3 * FL + FL + 4; c++) begin
            checks++;
            if (out_valid !== m_valid() || data_out !== m_data() || out_last !== m_last()
                || in_ready !== m_ready()) begin
                errors++;
                $display("FAIL b2b_cycle c=%0d got vld=%b dout=%h last=%b rdy=%b exp vld=%b dout=%h last=%b rdy=%b",
                         c, out_valid, data_out, out_last, in_ready, m_valid(), m_data(), m_last(), m_ready());
            end
            if (seen && outs < 3 * FL) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap c=%0d got vld=%b exp 1", c, out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                outs++;
            end
            tick(c < 3 * FL, rnd(), 1'b1);
        end
        checks++;
        if (outs != 3 * FL) begin
            errors++;
            $display("FAIL b2b_count got %0d exp %0d", outs, 3 * FL);
        end
    endtask

    task automatic test_stall_toggle();
        logic [DW-1:0] prev = '0;
        bit            stalled = 1'b0;
        int            outs = 0;
        for (int k = 0; k < FL; k++) tick(1'b1, rnd(), 1'b0);
        for (int c = 0; c < 4 * FL && m_valid(); c++) begin
            bit rdy = (c % 2) == 0;
            checks++;
            if (out_valid !== 1'b1 || data_out !== m_data() || out_last !== m_last()) begin
                errors++;
                $display("FAIL toggle_order c=%0d got vld=%b dout=%h last=%b exp vld=1 dout=%h last=%b",
                         c, out_valid, data_out, out_last, m_data(), m_last());
            end
            if (stalled) begin
                checks++;
                if (data_out !== prev) begin
                    errors++;
                    $display("FAIL toggle_hold c=%0d got %h exp %h", c, data_out, prev);
                end
            end
            if (rdy) outs++;
            prev    = m_data();
            stalled = !rdy;
            tick(1'b0, '0, rdy);
        end
        checks++;
        if (outs != FL || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL toggle_count got outs=%0d vld=%b exp outs=%0d vld=0", outs, out_valid, FL);
        end
    endtask

    task automatic test_coincident();
        for (int k = 0; k < 2 * FL - 1; k++) tick(1'b1, rnd(), 1'b0);
        for (int i = 0; i < FL - 1; i++) begin
            checks++;
            if (data_out !== m_data()) begin
                errors++;
                $display("FAIL coinc_a i=%0d got %h exp %h", i, data_out, m_data());
            end
            tick(1'b0, '0, 1'b1);
        end
        checks++;
        if (out_last !== 1'b1 || in_ready !== 1'b1 || data_out !== m_data()) begin
            errors++;
            $display("FAIL coinc_pre got last=%b rdy=%b dout=%h exp last=1 rdy=1 dout=%h",
                     out_last, in_ready, data_out, m_data());
        end
        tick(1'b1, rnd(), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || data_out !== m_data() || exp_q.size() != FL) begin
            errors++;
            $display("FAIL coinc_post got vld=%b rdy=%b dout=%h exp vld=1 rdy=1 dout=%h",
                     out_valid, in_ready, data_out, m_data());
        end
        for (int i = 0; i < FL + 2 && m_valid(); i++) begin
            checks++;
            if (data_out !== m_data() || out_last !== m_last()) begin
                errors++;
                $display("FAIL coinc_b i=%0d got dout=%h last=%b exp dout=%h last=%b",
                         i, data_out, out_last, m_data(), m_last());
            end
            tick(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_stall_full();
        for (int k = 0; k < 2 * FL; k++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill k=%0d got rdy=%b exp 1", k, in_ready);
            end
            tick(1'b1, rnd(), 1'b0);
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_rdy got rdy=%b vld=%b exp rdy=0 vld=1", in_ready, out_valid);
        end
        tick(1'b1, rnd(), 1'b0);
        checks++;
`ifdef FFT_REORDER_ERR_EN
        if (err_drop !== 1'b1) begin
            errors++;
            $display("FAIL full_err got %b exp 1", err_drop);
        end
`else
        if (err_drop !== 1'b0) begin
            errors++;
            $display("FAIL full_err got %b exp 0", err_drop);
        end
`endif
        for (int i = 0; i < 2 * FL + 2 && m_valid(); i++) begin
            checks++;
            if (data_out !== m_data() || out_last !== m_last() || in_ready !== m_ready()) begin
                errors++;
                $display("FAIL full_drain i=%0d got dout=%h last=%b rdy=%b exp dout=%h last=%b rdy=%b",
                         i, data_out, out_last, in_ready, m_data(), m_last(), m_ready());
            end
            tick(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_mid_frame_reset();
        for (int k = 0; k < FL + 5; k++) tick(1'b1, rnd(), 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({in_ready, out_valid, out_last, err_drop} !== 4'b0000 || data_out !== '0) begin
            errors++;
            $display("FAIL midrst_async got rdy=%b vld=%b last=%b err=%b dout=%h exp all 0",
                     in_ready, out_valid, out_last, err_drop, data_out);
        end
        @(posedge clk);
        #1;
        exp_q.delete();
        wcnt    = 0;
        rdy_ok  = 1'b0;
        err_exp = 1'b0;
        rst_n   = 1'b1;
        tick(1'b0, '0, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
        for (int c = 0; c < 2 * FL + 2; c++) begin
            checks++;
            if (out_valid !== m_valid() || data_out !== m_data() || out_last !== m_last()
                || err_drop !== err_exp) begin
                errors++;
                $display("FAIL midrst_frame c=%0d got vld=%b dout=%h last=%b err=%b exp vld=%b dout=%h last=%b err=%b",
                         c, out_valid, data_out, out_last, err_drop, m_valid(), m_data(), m_last(), err_exp);
            end
            tick(c < FL, rnd(), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_bitrev_frame();
        test_back_to_back();
        test_stall_toggle();
        test_coincident();
        test_stall_full();
        test_mid_frame_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 34, meaning sample width: {real[33:17], imag[16:0]}, both two's complement.
REQ-002 The block SHALL have parameter FRAME_LEN, default 8, meaning points per FFT frame; legal values are powers of two, 2..64.
REQ-003 The block SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port data_in  input  DATA_W  sample from FFT serial output, in bit-reversed order.
REQ-006 The block SHALL have port in_valid  input  1  data_in qualifier.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-008 The block SHALL have port data_out  output  DATA_W  sample in natural order.
REQ-009 The block SHALL have port out_valid  output  1  data_out qualifier.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts data_out.
REQ-011 The block SHALL have port out_last  output  1  high with the natural-index FRAME_LEN-1 sample.
REQ-012 The block SHALL have port err_drop  output  1  sticky: sample offered while in_ready low.

Function
REQ-013 An input transfer SHALL occur on any rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on any rising edge with out_valid=1 and out_ready=1.
REQ-014 The block SHALL hold two banks (A, B) of FRAME_LEN entries, each with status EMPTY or FULL.
REQ-015 Write side: sample k (0..FRAME_LEN-1, counted per frame) SHALL be stored at address bitrev(k) over log2(FRAME_LEN) bits in the current write bank.
REQ-016 On the transfer of sample FRAME_LEN-1, the write bank SHALL become FULL, the write counter SHALL wrap to 0 and the write bank pointer SHALL toggle.
REQ-017 in_ready SHALL be registered and SHALL equal 1 exactly when the current write bank is EMPTY.
REQ-018 Read side: out_valid SHALL be 1 exactly when the current read bank is FULL; data_out SHALL be entry rd_idx of that bank, with rd_idx counting 0..FRAME_LEN-1.
REQ-019 out_last SHALL be 1 exactly when out_valid=1 and rd_idx=FRAME_LEN-1.
REQ-020 On the output transfer with out_last=1, the read bank SHALL become EMPTY, rd_idx SHALL wrap to 0 and the read bank pointer SHALL toggle.
REQ-021 data_out SHALL hold the previous presented value while out_valid=1 and out_ready=0, and SHALL be 0 when out_valid=0.
REQ-022 Latency: out_valid SHALL rise on the first edge after the frame's last input transfer, and SHALL remain high for back-to-back frames without a bubble.
REQ-023 With out_ready held at 1, throughput SHALL be one sample per cycle in steady state.
REQ-024 Simultaneous events: a bank freed by the last output transfer in cycle t SHALL be reported by in_ready=1 from cycle t+1; a write completing a bank and a read freeing the other bank on the same edge SHALL both take effect.
REQ-025 With both banks FULL, in_ready SHALL be 0 and no stored data SHALL be overwritten.
REQ-026 The block SHALL perform no arithmetic on samples; values SHALL pass bit-exact.

Reset
REQ-027 Assertion of rst_n=0 SHALL, asynchronously and including mid-frame, set both banks EMPTY, counters to 0 and both bank pointers to A, and SHALL drive in_ready=0, out_valid=0, out_last=0, data_out=0 and err_drop=0.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts; a partial frame SHALL be discarded and the bank memory contents need not be cleared.

Configuration
REQ-029 With macro FFT_REORDER_ERR_EN defined, err_drop SHALL be set on any edge with in_valid=1 and in_ready=0, and SHALL clear only on reset.
REQ-030 With FFT_REORDER_ERR_EN undefined, err_drop SHALL be tied to 0, no detection logic SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-031 The bench SHALL cover: reset, then 8 samples with values 0..7 written in bit-reversed order 0,4,2,6,1,5,3,7 and out_ready=1 -> outputs in order 0..7 beginning the cycle after the 8th input, with out_last only on the 7.
REQ-032 The bench SHALL cover: 3 back-to-back frames with in_valid=1 and out_ready=1 throughout -> 24 outputs, with no out_valid gap after the first frame.
REQ-033 The bench SHALL cover: out_ready=0 while 2 frames are written -> in_ready=0 after the 16th sample, and a 17th offered sample sets err_drop=1 (macro defined) or leaves err_drop=0 (macro undefined).
REQ-034 The bench SHALL cover: out_ready toggled 1,0,1,0 during a read -> data_out stable while stalled and the full order 0..7 preserved.
REQ-035 The bench SHALL cover: rst_n pulsed low after the 5th sample of a frame -> outputs reset immediately, and the next full frame comes out correct with no residue.
REQ-036 The bench SHALL cover: last output of bank A on the same edge as the last input of bank B -> bank B read starts the next cycle and in_ready=1 the next cycle.
